// File: rtl/suma_pkg.sv
// Shared definitions for the keypad decimal adder: key codes, FSM states and
// the decimal range helper.
package suma_pkg;

   localparam int MAX_DIGITS_DEF = 4;
   localparam int RES_W_DEF      = 14;

   localparam logic [3:0] KEY_ADD   = 4'd10;
   localparam logic [3:0] KEY_EQUAL = 4'd11;
   localparam logic [3:0] KEY_CLEAR = 4'd12;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      SHOW    = 2'd2
   } state_t;

   // Largest value representable with the given number of decimal digits.
   function automatic int pow10_m1(input int digits);
      int v;
      v = 1;
      for (int i = 0; i < digits; i++) v = v * 10;
      return v - 1;
   endfunction

   localparam int MAX_VAL = pow10_m1(MAX_DIGITS_DEF);

endpackage

// File: rtl/suma_operand_acc.sv
// Decimal digit accumulator: value = value*10 + digit, limited to MAX_DIGITS
// digits, with synchronous clear and direct load.
module suma_operand_acc #(
   parameter int MAX_DIGITS = 4,
   parameter int RES_W      = 14,
   localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [RES_W-1:0] load_val,
   input  logic [CNT_W-1:0] load_cnt,
   input  logic             digit_en,
   input  logic [3:0]       digit,
   output logic [RES_W-1:0] value
);

   logic [CNT_W-1:0] count;
   logic             full;

   assign full = (count == CNT_W'(MAX_DIGITS));

   // Priority: clear, then load, then digit append (dropped once full).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         count <= '0;
      end else if (clear) begin
         value <= '0;
         count <= '0;
      end else if (load) begin
         value <= load_val;
         count <= load_cnt;
      end else if (digit_en && !full) begin
         value <= value * RES_W'(10) + RES_W'(digit);
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/suma.sv
// Keypad-driven decimal adder: builds two operands from key events and
// produces their saturated binary sum on EQUAL.
module suma
   import suma_pkg::*;
#(
   parameter int MAX_DIGITS = MAX_DIGITS_DEF,
   parameter int RES_W      = RES_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       key_code,
   input  logic             key_pulse,
   output logic [RES_W-1:0] result,
   output logic             result_valid,
   output logic             result_pulse,
   output logic             overflow
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [RES_W:0] MAX_V = (RES_W + 1)'(pow10_m1(MAX_DIGITS));

   // Key handshake: key_pulse is a one-cycle valid strobe with no ready; the
   // design accepts a key on every edge it is high, so back-to-back keys are
   // each consumed and key_code is don't-care while key_pulse is low.
   logic key_digit, key_add, key_eq, key_clr;
   assign key_digit = key_pulse && (key_code <= 4'd9);
   assign key_add   = key_pulse && (key_code == KEY_ADD);
   assign key_eq    = key_pulse && (key_code == KEY_EQUAL);
   assign key_clr   = key_pulse && (key_code == KEY_CLEAR);

   state_t state, state_nxt;

   logic             a_clr, a_load, a_dig, b_clr, b_dig;
   logic [RES_W-1:0] a_load_val;
   logic [CNT_W-1:0] a_load_cnt;
   logic             do_eq, start_new;
   logic [RES_W-1:0] a_val, b_val;
   logic [RES_W:0]   sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ENTER_A;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (key_clr) begin
         state_nxt = ENTER_A;
      end else begin
         case (state)
            ENTER_A: if (key_add) state_nxt = ENTER_B;
                     else if (key_eq) state_nxt = SHOW;
            ENTER_B: if (key_eq) state_nxt = SHOW;
            SHOW:    if (key_digit) state_nxt = ENTER_A;
                     else if (key_add) state_nxt = ENTER_B;
            default: state_nxt = ENTER_A;
         endcase
      end
   end

   always_comb begin
      a_clr      = key_clr;
      b_clr      = key_clr;
      a_load     = 1'b0;
      a_load_val = '0;
      a_load_cnt = '0;
      a_dig      = 1'b0;
      b_dig      = 1'b0;
      do_eq      = 1'b0;
      start_new  = 1'b0;
      case (state)
         ENTER_A: begin
            a_dig = key_digit;
            b_clr = key_clr || key_add;
            do_eq = key_eq;
         end
         ENTER_B: begin
            b_dig = key_digit;
            do_eq = key_eq;
         end
         SHOW: begin
            // A new digit restarts entry with A = d; ADD chains from result.
            if (key_digit) begin
               a_load     = 1'b1;
               a_load_val = RES_W'(key_code);
               a_load_cnt = CNT_W'(1);
               b_clr      = 1'b1;
               start_new  = 1'b1;
            end else if (key_add) begin
               a_load     = 1'b1;
               a_load_val = result;
               a_load_cnt = CNT_W'(MAX_DIGITS);
               b_clr      = 1'b1;
            end
         end
         default: ;
      endcase
   end

   suma_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .RES_W(RES_W)) u_acc_a (
      .clk(clk), .rst(rst), .clear(a_clr), .load(a_load),
      .load_val(a_load_val), .load_cnt(a_load_cnt),
      .digit_en(a_dig), .digit(key_code), .value(a_val)
   );

   suma_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .RES_W(RES_W)) u_acc_b (
      .clk(clk), .rst(rst), .clear(b_clr), .load(1'b0),
      .load_val('0), .load_cnt('0),
      .digit_en(b_dig), .digit(key_code), .value(b_val)
   );

   assign sum = {1'b0, a_val} + ((state == ENTER_B) ? {1'b0, b_val} : '0);

   // eq_seen delays the strobe so result_pulse lands one cycle after the
   // EQUAL edge, when result is already stable.
   logic eq_seen;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result       <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         eq_seen      <= 1'b0;
         result_pulse <= 1'b0;
      end else if (key_clr) begin
         result       <= '0;
         result_valid <= 1'b0;
         overflow     <= 1'b0;
         eq_seen      <= 1'b0;
         result_pulse <= 1'b0;
      end else begin
         eq_seen      <= do_eq;
         result_pulse <= eq_seen;
         if (do_eq) begin
            result_valid <= 1'b1;
            overflow     <= (sum > MAX_V);
            result       <= (sum > MAX_V) ? MAX_V[RES_W-1:0] : sum[RES_W-1:0];
         end else if (start_new) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_suma.sv
// Directed table-driven bench for the keypad decimal adder, with a
// result_pulse scoreboard and a hand-written asynchronous reset sequence.
module tb_suma;
   import suma_pkg::*;

   localparam int RES_W = 14;

   typedef struct packed {
      logic             kp;
      logic [3:0]       code;
      logic             push;
      logic [RES_W-1:0] res;
      logic             valid;
      logic             pulse;
      logic             ovf;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       key_code;
   logic             key_pulse;
   logic [RES_W-1:0] result;
   logic             result_valid;
   logic             result_pulse;
   logic             overflow;

   int n_checks = 0;
   int n_pass   = 0;
   int n_push   = 0;
   int n_pulse  = 0;

   logic [RES_W-1:0] exp_q[$];
   vec_t             vecs[$];

   // Clock / reset
   always #5 clk = ~clk;

   suma #(.MAX_DIGITS(4), .RES_W(RES_W)) dut (
      .clk(clk), .rst(rst), .key_code(key_code), .key_pulse(key_pulse),
      .result(result), .result_valid(result_valid),
      .result_pulse(result_pulse), .overflow(overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input logic kp, input logic [3:0] code, input logic push,
                      input int res, input logic v, input logic p, input logic o);
      vec_t e;
      e.kp = kp; e.code = code; e.push = push; e.res = RES_W'(res);
      e.valid = v; e.pulse = p; e.ovf = o;
      vecs.push_back(e);
   endtask

   // Driver: one key per cycle, changed on the falling edge.
   task automatic press(input logic [3:0] code);
      key_pulse = 1'b1;
      key_code  = code;
      @(negedge clk);
      key_pulse = 1'b0;
   endtask

   // Scoreboard: every result_pulse must match the next expected sum.
   always @(negedge clk) begin
      if (result_pulse === 1'b1 && rst === 1'b0) begin
         n_pulse++;
         if (exp_q.size() == 0) check("pulse_unexpected", n_pulse, n_push);
         else check("pulse_result", 32'(result), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      rst = 1'b1; key_pulse = 1'b0; key_code = 4'd0;

      // 1,5,ADD,2,7,EQUAL -> 42
      add(1,1,0,0,0,0,0); add(1,5,0,0,0,0,0); add(1,KEY_ADD,0,0,0,0,0);
      add(1,2,0,0,0,0,0); add(1,7,0,0,0,0,0); add(1,KEY_EQUAL,1,42,1,0,0);
      add(0,7,0,42,1,1,0); add(0,7,0,42,1,0,0);
      // CLEAR,8,(idle with stray code),ADD,5,EQUAL -> 13
      add(1,KEY_CLEAR,0,0,0,0,0); add(1,8,0,0,0,0,0); add(0,7,0,0,0,0,0);
      add(1,KEY_ADD,0,0,0,0,0); add(1,5,0,0,0,0,0); add(1,KEY_EQUAL,1,13,1,0,0);
      add(0,7,0,13,1,1,0);
      // digit in SHOW starts new op: 9999 + 9999 saturates with overflow
      add(1,9,0,13,0,0,0); add(1,9,0,13,0,0,0); add(1,9,0,13,0,0,0); add(1,9,0,13,0,0,0);
      add(1,KEY_ADD,0,13,0,0,0);
      add(1,9,0,13,0,0,0); add(1,9,0,13,0,0,0); add(1,9,0,13,0,0,0); add(1,9,0,13,0,0,0);
      add(1,KEY_EQUAL,1,9999,1,0,1); add(0,7,0,9999,1,1,1);
      add(1,4'd13,0,9999,1,0,1); add(1,KEY_CLEAR,0,0,0,0,0);
      // fifth digit ignored: 1234 + 1 = 1235, then EQUAL in SHOW ignored
      add(1,1,0,0,0,0,0); add(1,2,0,0,0,0,0); add(1,3,0,0,0,0,0); add(1,4,0,0,0,0,0);
      add(1,5,0,0,0,0,0); add(1,KEY_ADD,0,0,0,0,0); add(1,1,0,0,0,0,0);
      add(1,KEY_EQUAL,1,1235,1,0,0); add(0,7,0,1235,1,1,0);
      add(1,KEY_EQUAL,0,1235,1,0,0); add(0,7,0,1235,1,0,0);
      // chain: 4+6 = 10, ADD 5 -> 15
      add(1,KEY_CLEAR,0,0,0,0,0); add(1,4,0,0,0,0,0); add(1,KEY_ADD,0,0,0,0,0);
      add(1,6,0,0,0,0,0); add(1,KEY_EQUAL,1,10,1,0,0); add(1,KEY_ADD,0,10,1,1,0);
      add(1,5,0,10,1,0,0); add(1,KEY_EQUAL,1,15,1,0,0); add(0,7,0,15,1,1,0);
      // EQUAL straight from ENTER_A, then ADD ignored in ENTER_B: 1 + 23 = 24
      add(1,KEY_CLEAR,0,0,0,0,0); add(1,3,0,0,0,0,0); add(1,KEY_EQUAL,1,3,1,0,0);
      add(0,7,0,3,1,1,0); add(1,1,0,3,0,0,0); add(1,KEY_ADD,0,3,0,0,0);
      add(1,2,0,3,0,0,0); add(1,KEY_ADD,0,3,0,0,0); add(1,3,0,3,0,0,0);
      add(1,KEY_EQUAL,1,24,1,0,0); add(0,7,0,24,1,1,0);

      repeat (2) @(negedge clk);
      check("reset_result", 32'(result), 0);
      check("reset_valid", 32'(result_valid), 0);
      check("reset_pulse", 32'(result_pulse), 0);
      check("reset_overflow", 32'(overflow), 0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         key_pulse = vecs[i].kp;
         key_code  = vecs[i].code;
         if (vecs[i].push) begin
            exp_q.push_back(vecs[i].res);
            n_push++;
         end
         @(negedge clk);
         check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
         check($sformatf("v%0d_valid", i), 32'(result_valid), 32'(vecs[i].valid));
         check($sformatf("v%0d_pulse", i), 32'(result_pulse), 32'(vecs[i].pulse));
         check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      end
      key_pulse = 1'b0;

      // Reset asserted mid-entry, away from any clock edge.
      press(4'd7); press(KEY_ADD); press(4'd3);
      check("pre_reset_result", 32'(result), 24);
      #2 rst = 1'b1;
      #1;
      check("async_reset_result", 32'(result), 0);
      check("async_reset_valid", 32'(result_valid), 0);
      check("async_reset_overflow", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(RES_W'(2));
      n_push++;
      press(4'd2); press(KEY_EQUAL);
      check("post_reset_result", 32'(result), 2);
      check("post_reset_valid", 32'(result_valid), 1);
      repeat (2) @(negedge clk);

      check("pulse_count", n_pulse, n_push);
      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
